mem_arbiter: RTL and testbench

- Sits directly upstream of the fetch stage's instruction cache and beside the data cache.
- Shares one line-wide main-memory port between the I-cache and D-cache refill/writeback interfaces.
- Grants one requester at a time, forwards its request to memory, captures the returned line, and returns a one-cycle ready pulse to the granted requester.
- Ties between requesters are resolved round-robin so that neither cache starves.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D-cache main-memory arbiter.
package mem_pkg;

    localparam int CACHE_LINE_SIZE_DEFAULT = 128;
    localparam int ADDR_WIDTH_DEFAULT      = 32;

    // Arbiter control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    // Which requester owns, or last owned, the memory port.
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the
// I-cache refill path and the D-cache refill/writeback path. One
// transaction is in flight at a time. The granted request is latched, so
// memory sees stable strobes and address even if the cache changes its
// inputs. Completion is reported with a one-cycle ready pulse.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int CACHE_LINE_SIZE = CACHE_LINE_SIZE_DEFAULT,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    // I-cache side
    input  logic                       in_i_read_en,
    input  logic [ADDR_WIDTH-1:0]      in_i_addr,
    output logic [CACHE_LINE_SIZE-1:0] out_i_read_data,
    output logic                       out_i_ready,
    // D-cache side
    input  logic                       in_d_read_en,
    input  logic                       in_d_write_en,
    input  logic [ADDR_WIDTH-1:0]      in_d_addr,
    input  logic [CACHE_LINE_SIZE-1:0] in_d_write_data,
    output logic [CACHE_LINE_SIZE-1:0] out_d_read_data,
    output logic                       out_d_ready,
    // Main-memory side
    output logic                       out_mem_read_en,
    output logic                       out_mem_write_en,
    output logic [ADDR_WIDTH-1:0]      out_mem_addr,
    output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
    input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
    input  logic                       in_mem_ready
);

    arb_state_t                 r_state;
    grant_t                     r_last_grant;
    logic                       r_op_write;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [CACHE_LINE_SIZE-1:0] r_wdata;

    logic w_i_req;
    logic w_d_req;
    logic w_any_req;
    logic w_d_wins;

    // A D request is either a refill or a writeback. A tie goes to the
    // requester that did not win last time, so neither cache starves.
    assign w_i_req   = in_i_read_en;
    assign w_d_req   = in_d_read_en | in_d_write_en;
    assign w_any_req = w_i_req | w_d_req;
    assign w_d_wins  = w_d_req & (~w_i_req | (r_last_grant == GRANT_I));

    // The memory address and write line are taken from the grant latches.
    assign out_mem_addr       = r_addr;
    assign out_mem_write_data = r_wdata;

    // Arbiter FSM: grant, hold strobes until memory completes, one response
    // cycle, then back to IDLE. Strobes and ready pulses are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= IDLE;
            r_last_grant     <= GRANT_I;
            r_op_write       <= 1'b0;
            r_addr           <= '0;
            r_wdata          <= '0;
            out_mem_read_en  <= 1'b0;
            out_mem_write_en <= 1'b0;
            out_i_ready      <= 1'b0;
            out_d_ready      <= 1'b0;
            out_i_read_data  <= '0;
            out_d_read_data  <= '0;
        end else begin
            // Ready is a pulse. Only the completion branch raises it.
            out_i_ready <= 1'b0;
            out_d_ready <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        if (w_d_wins) begin
                            // Write wins when the D-cache raises both strobes.
                            r_addr           <= in_d_addr;
                            r_wdata          <= in_d_write_data;
                            r_op_write       <= in_d_write_en;
                            out_mem_read_en  <= ~in_d_write_en;
                            out_mem_write_en <= in_d_write_en;
                            r_last_grant     <= GRANT_D;
                            r_state          <= BUSY_D;
                        end else begin
                            r_addr           <= in_i_addr;
                            r_op_write       <= 1'b0;
                            out_mem_read_en  <= 1'b1;
                            out_mem_write_en <= 1'b0;
                            r_last_grant     <= GRANT_I;
                            r_state          <= BUSY_I;
                        end
                    end
                end

                BUSY_I, BUSY_D: begin
                    // Requester inputs are ignored here. Only memory moves us on.
                    if (in_mem_ready) begin
                        out_mem_read_en  <= 1'b0;
                        out_mem_write_en <= 1'b0;
                        r_state          <= RESP;
                        if (r_state == BUSY_I) begin
                            out_i_ready     <= 1'b1;
                            out_i_read_data <= in_mem_read_data;
                        end else begin
                            out_d_ready <= 1'b1;
                            if (!r_op_write)
                                out_d_read_data <= in_mem_read_data;
                        end
                    end
                end

                // The requester may still be asserting during its ready cycle.
                // Skipping arbitration here keeps that stale request from
                // being granted again.
                RESP: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. The bench drives memory completions
// by hand and checks every expected value against constants.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int LW = 128;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_i_read_en = 1'b0;
    logic [AW-1:0] in_i_addr = '0;
    logic [LW-1:0] out_i_read_data;
    logic          out_i_ready;
    logic          in_d_read_en = 1'b0;
    logic          in_d_write_en = 1'b0;
    logic [AW-1:0] in_d_addr = '0;
    logic [LW-1:0] in_d_write_data = '0;
    logic [LW-1:0] out_d_read_data;
    logic          out_d_ready;
    logic          out_mem_read_en;
    logic          out_mem_write_en;
    logic [AW-1:0] out_mem_addr;
    logic [LW-1:0] out_mem_write_data;
    logic [LW-1:0] in_mem_read_data = '0;
    logic          in_mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam logic [LW-1:0] LINE1 = 128'hDEADBEEF_00000000_00000000_00000001;
    localparam logic [LW-1:0] LINE2 = 128'h22222222_33333333_44444444_55555555;
    localparam logic [LW-1:0] LINE3 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [LW-1:0] LINE5 = 128'h5555_AAAA_5555_AAAA_1111_2222_3333_4444;
    localparam logic [LW-1:0] JUNK  = {LW{1'b1}};
    localparam logic [LW-1:0] A5    = {16{8'hA5}};

    mem_arbiter #(.CACHE_LINE_SIZE(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .in_i_read_en(in_i_read_en), .in_i_addr(in_i_addr),
        .out_i_read_data(out_i_read_data), .out_i_ready(out_i_ready),
        .in_d_read_en(in_d_read_en), .in_d_write_en(in_d_write_en),
        .in_d_addr(in_d_addr), .in_d_write_data(in_d_write_data),
        .out_d_read_data(out_d_read_data), .out_d_ready(out_d_ready),
        .out_mem_read_en(out_mem_read_en), .out_mem_write_en(out_mem_write_en),
        .out_mem_addr(out_mem_addr), .out_mem_write_data(out_mem_write_data),
        .in_mem_read_data(in_mem_read_data), .in_mem_ready(in_mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset state ----
        tick();
        chk("rst_rd_en", LW'(out_mem_read_en), '0);
        chk("rst_wr_en", LW'(out_mem_write_en), '0);
        chk("rst_addr", LW'(out_mem_addr), '0);
        chk("rst_i_ready", LW'(out_i_ready), '0);
        chk("rst_d_ready", LW'(out_d_ready), '0);
        chk("rst_i_data", out_i_read_data, '0);
        reset = 1'b0;
        tick();

        // ---- 1: I-only read ----
        in_i_read_en = 1'b1; in_i_addr = 32'h40;
        tick();
        chk("t1_rd_en", LW'(out_mem_read_en), LW'(1));
        chk("t1_wr_en", LW'(out_mem_write_en), '0);
        chk("t1_addr", LW'(out_mem_addr), LW'(32'h40));
        tick();
        tick();
        chk("t1_rd_en_held", LW'(out_mem_read_en), LW'(1));
        chk("t1_no_early_ready", LW'(out_i_ready), '0);
        in_mem_ready = 1'b1; in_mem_read_data = LINE1;
        tick();
        in_mem_ready = 1'b0; in_mem_read_data = JUNK;
        chk("t1_i_ready", LW'(out_i_ready), LW'(1));
        chk("t1_i_data", out_i_read_data, LINE1);
        chk("t1_d_ready", LW'(out_d_ready), '0);
        chk("t1_rd_dropped", LW'(out_mem_read_en), '0);
        in_i_read_en = 1'b0;
        tick();
        chk("t1_ready_pulse", LW'(out_i_ready), '0);
        tick();

        // ---- in_mem_ready in IDLE is ignored ----
        in_mem_ready = 1'b1;
        tick();
        in_mem_ready = 1'b0;
        chk("idle_mr_i", LW'(out_i_ready), '0);
        chk("idle_mr_d", LW'(out_d_ready), '0);
        chk("idle_mr_rd", LW'(out_mem_read_en), '0);

        // ---- 2: simultaneous I and D after reset, D first ----
        reset = 1'b1; tick(); reset = 1'b0;
        in_i_read_en = 1'b1; in_i_addr = 32'h100;
        in_d_read_en = 1'b1; in_d_addr = 32'h200;
        tick();
        chk("t2_first_addr", LW'(out_mem_addr), LW'(32'h200));
        chk("t2_first_rd", LW'(out_mem_read_en), LW'(1));
        in_mem_ready = 1'b1; in_mem_read_data = LINE2;
        tick();
        in_mem_ready = 1'b0;
        chk("t2_d_ready", LW'(out_d_ready), LW'(1));
        chk("t2_i_not_ready", LW'(out_i_ready), '0);
        chk("t2_d_data", out_d_read_data, LINE2);
        in_d_read_en = 1'b0;
        tick();
        chk("t2_gap_rd", LW'(out_mem_read_en), '0);
        tick();
        chk("t2_second_addr", LW'(out_mem_addr), LW'(32'h100));
        chk("t2_second_rd", LW'(out_mem_read_en), LW'(1));
        in_mem_ready = 1'b1; in_mem_read_data = LINE3;
        tick();
        in_mem_ready = 1'b0;
        chk("t2_i_ready", LW'(out_i_ready), LW'(1));
        chk("t2_i_data", out_i_read_data, LINE3);
        chk("t2_d_data_held", out_d_read_data, LINE2);
        in_i_read_en = 1'b0;
        tick();

        // ---- 3: D write; read data must stay untouched ----
        in_d_write_en = 1'b1; in_d_addr = 32'h80; in_d_write_data = A5;
        tick();
        chk("t3_wr_en", LW'(out_mem_write_en), LW'(1));
        chk("t3_rd_en", LW'(out_mem_read_en), '0);
        chk("t3_addr", LW'(out_mem_addr), LW'(32'h80));
        chk("t3_wdata", out_mem_write_data, A5);
        in_d_write_data = '0; in_d_addr = 32'h9999;
        tick();
        chk("t3_wr_held", LW'(out_mem_write_en), LW'(1));
        chk("t3_wdata_latched", out_mem_write_data, A5);
        chk("t3_addr_latched", LW'(out_mem_addr), LW'(32'h80));
        in_mem_ready = 1'b1; in_mem_read_data = JUNK;
        tick();
        in_mem_ready = 1'b0;
        chk("t3_d_ready", LW'(out_d_ready), LW'(1));
        chk("t3_wr_dropped", LW'(out_mem_write_en), '0);
        chk("t3_d_data_unchanged", out_d_read_data, LINE2);
        in_d_write_en = 1'b0;
        tick();

        // ---- read and write together are treated as a write ----
        in_d_read_en = 1'b1; in_d_write_en = 1'b1; in_d_addr = 32'hC0;
        tick();
        chk("rw_wr_en", LW'(out_mem_write_en), LW'(1));
        chk("rw_rd_en", LW'(out_mem_read_en), '0);
        in_mem_ready = 1'b1; in_mem_read_data = LINE1;
        tick();
        in_mem_ready = 1'b0;
        chk("rw_d_data_unchanged", out_d_read_data, LINE2);
        in_d_read_en = 1'b0; in_d_write_en = 1'b0;
        tick();

        // ---- 4: fairness with both held, starting from reset ----
        reset = 1'b1; tick(); reset = 1'b0;
        in_i_read_en = 1'b1; in_i_addr = 32'h100;
        in_d_read_en = 1'b1; in_d_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t4_addr_%0d", k), LW'(out_mem_addr),
                LW'((k % 2 == 0) ? 32'h200 : 32'h100));
            in_mem_ready = 1'b1;
            tick();
            in_mem_ready = 1'b0;
            chk($sformatf("t4_d_ready_%0d", k), LW'(out_d_ready), LW'(k % 2 == 0));
            chk($sformatf("t4_i_ready_%0d", k), LW'(out_i_ready), LW'(k % 2 == 1));
            tick();
        end
        in_i_read_en = 1'b0; in_d_read_en = 1'b0;
        tick();
        tick();

        // ---- 5: reset mid BUSY_I, then a clean I read ----
        in_i_read_en = 1'b1; in_i_addr = 32'h300;
        tick();
        chk("t5_busy_rd", LW'(out_mem_read_en), LW'(1));
        reset = 1'b1;
        #1;
        chk("t5_rst_rd", LW'(out_mem_read_en), '0);
        chk("t5_rst_addr", LW'(out_mem_addr), '0);
        chk("t5_rst_i_data", out_i_read_data, '0);
        in_mem_ready = 1'b1;
        tick();
        in_mem_ready = 1'b0;
        chk("t5_rst_no_ready", LW'(out_i_ready), '0);
        reset = 1'b0;
        tick();
        chk("t5_regrant_addr", LW'(out_mem_addr), LW'(32'h300));
        chk("t5_regrant_rd", LW'(out_mem_read_en), LW'(1));
        in_mem_ready = 1'b1; in_mem_read_data = LINE5;
        tick();
        in_mem_ready = 1'b0;
        chk("t5_i_ready", LW'(out_i_ready), LW'(1));
        chk("t5_i_data", out_i_read_data, LINE5);

        // ---- 6: stale request held across the ready cycle ----
        tick();
        in_i_read_en = 1'b0;
        chk("t6_no_regrant", LW'(out_mem_read_en), '0);
        chk("t6_ready_gone", LW'(out_i_ready), '0);
        tick();
        chk("t6_still_idle", LW'(out_mem_read_en), '0);
        tick();
        chk("t6_idle_again", LW'(out_mem_read_en), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case stimulus ever stalls.
    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
